// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial2parallel deserializer.
// The PARITY state is only reachable when S2P_PARITY_EN is defined.
package s2p_pkg;

  typedef enum logic [1:0] {
    S2P_IDLE   = 2'd0,
    S2P_SHIFT  = 2'd1,
    S2P_PARITY = 2'd2
  } s2p_state_t;

  localparam int S2P_MIN_WIDTH = 2;

endpackage

// File: rtl/s2p_out_reg.sv
// Valid/ready holding register for assembled words; a word completing while
// the previous one is still unconsumed is dropped and flagged as overrun.
module s2p_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word,
  input  logic             load,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  // A consume and a load in the same cycle hand over without a bubble.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    if (load) begin
      if (!dout_valid_q || ready) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/serial2parallel.sv
// MSB-first serial-to-parallel deserializer framed by a start-of-word strobe.
// Define S2P_PARITY_EN to append and check an even-parity bit per word.
module serial2parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err
`ifdef S2P_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < S2P_MIN_WIDTH) begin : g_width_check
    $error("serial2parallel: WIDTH must be at least 2");
  end

  s2p_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic             frame_err_q, frame_err_d;
`ifdef S2P_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif
  logic             last_bit;

  assign last_bit = (count_q == CNT_W'(WIDTH - 1));

  // A sof always starts a fresh word; it is a framing error unless idle.
  // Completion raises done_q, and the output register picks up shift_q on
  // the following edge, so a new word may already start on that same edge.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef S2P_PARITY_EN
    parity_err_d = 1'b0;
`endif
    if (din_valid) begin
      if (sof) begin
        frame_err_d        = (state_q != S2P_IDLE);
        shift_d            = '0;
        shift_d[WIDTH-1]   = din;
        count_d            = CNT_W'(1);
        state_d            = S2P_SHIFT;
      end else begin
        case (state_q)
          S2P_SHIFT: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (count_q == CNT_W'(WIDTH - 1 - i)) shift_d[i] = din;
            end
            if (last_bit) begin
              count_d = '0;
`ifdef S2P_PARITY_EN
              state_d = S2P_PARITY;
`else
              state_d = S2P_IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
`ifdef S2P_PARITY_EN
          S2P_PARITY: begin
            state_d = S2P_IDLE;
            if (^{shift_q, din}) parity_err_d = 1'b1;
            else                 done_d       = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S2P_IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef S2P_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
`ifdef S2P_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  s2p_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .word       (shift_q),
    .load       (done_q),
    .ready      (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

  assign frame_err = frame_err_q;
`ifdef S2P_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial2parallel.sv
// Directed testbench for serial2parallel with WIDTH=4.
// Compiles with or without S2P_PARITY_EN; parity bits are appended when defined.
module tb_serial2parallel;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overrun;
  logic       frame_err;
`ifdef S2P_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  serial2parallel #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
`ifdef S2P_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid bit for exactly one edge; returns 1 time unit after it.
  task automatic drive_bit(input logic b, input logic s);
    din       = b;
    sof       = s;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) drive_bit(w[i], i == 3);
`ifdef S2P_PARITY_EN
    drive_bit(^w, 1'b0);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (dout !== 4'h0) begin errors++; $display("[TB] FAIL reset_dout: got %h expected %h", dout, 4'h0); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", dout_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    send_word(4'b1011);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency: got valid %b expected 0", dout_valid); end
    tick();
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", dout_valid); end
    checks++; if (dout !== 4'b1011) begin errors++; $display("[TB] FAIL basic_dout: got %b expected 1011", dout); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_errors: got ovr %b frm %b expected 0 0", overrun, frame_err); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_consumed: got valid %b expected 0", dout_valid); end
  endtask

  task automatic test_gaps();
    dout_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    tick();
    drive_bit(1'b1, 1'b0);
    tick();
    tick();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
`ifdef S2P_PARITY_EN
    drive_bit(1'b1, 1'b0);
`endif
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'b1101) begin errors++; $display("[TB] FAIL gaps_word: got valid %b dout %b expected 1 1101", dout_valid, dout); end
    tick();
  endtask

  task automatic test_back_to_back();
    dout_ready = 1'b0;
    send_word(4'hA);
    send_word(4'h5);
    checks++; if (dout_valid !== 1'b1 || dout !== 4'hA) begin errors++; $display("[TB] FAIL b2b_first: got valid %b dout %h expected 1 a", dout_valid, dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_early_ovr: got %b expected 0", overrun); end
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 1", overrun); end
    checks++; if (dout !== 4'hA) begin errors++; $display("[TB] FAIL b2b_hold: got %h expected a", dout); end
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovr_pulse: got %b expected 0", overrun); end
    checks++; if (dout_valid !== 1'b1 || dout !== 4'hA) begin errors++; $display("[TB] FAIL b2b_still_a: got valid %b dout %h expected 1 a", dout_valid, dout); end
    dout_ready = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got valid %b expected 0", dout_valid); end
  endtask

  task automatic test_frame_error();
    dout_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL frame_pulse: got %b expected 1", frame_err); end
    drive_bit(1'b1, 1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL frame_one_cycle: got %b expected 0", frame_err); end
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
`ifdef S2P_PARITY_EN
    drive_bit(1'b0, 1'b0);
`endif
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'b0110) begin errors++; $display("[TB] FAIL frame_word: got valid %b dout %b expected 1 0110", dout_valid, dout); end
    tick();
  endtask

  task automatic test_simultaneous();
    dout_ready = 1'b0;
    send_word(4'hC);
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'hC) begin errors++; $display("[TB] FAIL simul_first: got valid %b dout %h expected 1 c", dout_valid, dout); end
    send_word(4'h3);
    dout_ready = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'h3) begin errors++; $display("[TB] FAIL simul_load: got valid %b dout %h expected 1 3", dout_valid, dout); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL simul_overrun: got %b expected 0", overrun); end
    dout_ready = 1'b0;
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'h3) begin errors++; $display("[TB] FAIL simul_hold: got valid %b dout %h expected 1 3", dout_valid, dout); end
    dout_ready = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL simul_drain: got valid %b expected 0", dout_valid); end
  endtask

  task automatic test_reset_midword();
    dout_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    checks++; if (dout !== 4'h0) begin errors++; $display("[TB] FAIL rst_mid_dout: got %h expected 0", dout); end
    checks++; if (dout_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_flags: got valid %b ovr %b frm %b expected 0 0 0", dout_valid, overrun, frame_err); end
    rst_n = 1'b1;
    drive_bit(1'b1, 1'b0);
    send_word(4'b0111);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_frame: got %b expected 0", frame_err); end
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'b0111) begin errors++; $display("[TB] FAIL rst_mid_word: got valid %b dout %b expected 1 0111", dout_valid, dout); end
    tick();
  endtask

`ifdef S2P_PARITY_EN
  task automatic test_parity();
    dout_ready = 1'b1;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_good_err: got %b expected 0", parity_err); end
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'b1011) begin errors++; $display("[TB] FAIL parity_good_word: got valid %b dout %b expected 1 1011", dout_valid, dout); end
    tick();
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_err: got %b expected 1", parity_err); end
    tick();
    checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_pulse: got %b expected 0", parity_err); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL parity_discard: got valid %b expected 0", dout_valid); end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    sof        = 1'b0;
    dout_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_frame_error();
    test_simultaneous();
    test_reset_midword();
`ifdef S2P_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial2parallel.md
# serial2parallel

Deserializer that rebuilds WIDTH-bit words from a 1-bit MSB-first serial stream, framed by a start-of-word strobe. It is the receive end of the team's parallel-to-serial link and sits between the serial line and the word-level consumer. Assembled words are delivered through a valid/ready output register. Overrun and framing errors are flagged, not stalled, because the serial side cannot be back-pressured.

## Interface
- WIDTH, 4, word width in bits, minimum 2.
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  1  serial data bit, MSB of the word first.
- din_valid  input  1  din is sampled on this edge; when 0, the bit is ignored.
- sof  input  1  start of word; qualified by din_valid, marks din as the word MSB.
- dout  output  WIDTH  assembled word; stable while dout_valid=1.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
- overrun  output  1  one-cycle pulse; a completed word was dropped.
- frame_err  output  1  one-cycle pulse; sof arrived mid-word.
- parity_err  output  1  one-cycle pulse; only present with S2P_PARITY_EN.

## Operation
- The state machine has three states: IDLE, SHIFT and PARITY. PARITY exists only with S2P_PARITY_EN.
- IDLE:
  - din_valid & sof loads din into shift[WIDTH-1], sets bit count to 1, and moves to SHIFT.
  - din_valid without sof is ignored.
- SHIFT:
  - Each din_valid shifts din in, with the MSB accepted first, and increments the count.
  - When count reaches WIDTH, the word is complete. The FSM moves to IDLE, or to PARITY if enabled.
  - din_valid & sof while in SHIFT pulses frame_err and discards the partial word. The current bit restarts a new word as its MSB with count=1, and the FSM stays in SHIFT.
- PARITY:
  - The next din_valid bit is the even-parity bit over the word, i.e. the XOR of the word and the parity bit must equal 0.
  - On mismatch, parity_err pulses and the word is discarded.
  - sof in PARITY is a framing error: frame_err pulses, the word is discarded, and a new word starts with this bit as MSB.
- Word delivery, on completion:
  - If dout_valid=0, or dout_valid & dout_ready in the same cycle, dout is loaded and dout_valid=1.
  - If dout_valid=1 & dout_ready=0, the new word is dropped, overrun pulses, and dout keeps the old word.
  - With no completion, dout_valid & dout_ready clears dout_valid.
- Count width is $clog2(WIDTH+1). The count never exceeds WIDTH and wraps to 0 on completion.
- All error pulses are independent, and several may assert in the same cycle.

## Timing
- Reset values: dout=0, dout_valid=0, overrun=0, frame_err=0, parity_err=0; FSM in IDLE with count=0.
- Reset has priority over every input and aborts any partial word, with no error pulse.
- Latency without parity: last data bit sampled at edge N gives dout_valid=1 after edge N+1's register update, i.e. visible in cycle N+1.
- Latency with parity: dout_valid is visible one cycle after the parity bit is sampled.
- A new word may start (sof) on the edge immediately after the last bit, giving a gapless stream.
- Throughput is 1 word per WIDTH cycles, or WIDTH+1 with parity. The consumer must drain within that window to avoid overrun.
- Error pulses are registered and asserted for exactly the one cycle after the offending edge.

## Configuration
- S2P_PARITY_EN defined: the PARITY state, even-parity check and parity_err port are compiled in. A frame is WIDTH+1 bits.
- S2P_PARITY_EN undefined: no PARITY state and no parity_err port. A frame is WIDTH bits.

## Structure
- Package s2p_pkg holds:
  - the state enum s2p_state_t (S2P_IDLE, S2P_SHIFT, S2P_PARITY);
  - the constant S2P_MIN_WIDTH=2.
- One sub-module, s2p_out_reg: the valid/ready holding register with overrun detection. Inputs are word, load and ready; outputs are dout, dout_valid and overrun.
- The top level holds the FSM, shift register and counter.

## Test plan
- WIDTH=4, no parity, bits 1,0,1,1 with sof on the first bit and dout_ready=1 -> dout=4'b1011, dout_valid for 1 cycle, no errors.
- Two gapless words 4'hA then 4'h5, dout_ready=0 until after the second word completes -> dout stays 4'hA, overrun pulses once at the second completion, then 4'hA is consumed.
- sof after 2 bits (1,1), then full word 0,1,1,0 -> frame_err pulse on the restart edge, delivered dout=4'b0110.
- Completion in the same cycle as dout_valid & dout_ready -> new word loaded, dout_valid stays 1, no overrun.
- rst_n=0 after 3 bits of a word -> all outputs 0, the next sof-framed word is delivered correctly.
- S2P_PARITY_EN, word 4'b1011 with parity 1 -> delivered; the same word with parity 0 -> parity_err pulse, dout_valid stays 0.
